// File: rtl/mbinit_step_handshake.sv
// MBINIT sideband handshake for one training step: a local requester and a
// local responder run concurrently and share one sideband TX port. Includes
// a step timeout and a synchronous abort.
module mbinit_step_handshake #(
  parameter int unsigned      MSG_W       = 4,
  parameter logic [MSG_W-1:0] REQ_CODE    = MSG_W'(1),
  parameter logic [MSG_W-1:0] RESP_CODE   = MSG_W'(2),
  parameter int unsigned      TIMEOUT_CYC = 1000,
  parameter int unsigned      CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             i_step_en,
  input  logic             i_train_error_req,
  input  logic [MSG_W-1:0] i_RX_SbMessage,
  input  logic             i_msg_valid,
  input  logic             i_falling_edge_busy,
  output logic [MSG_W-1:0] o_TX_SbMessage,
  output logic             o_tx_valid,
  output logic             o_step_end,
  output logic             o_timeout_err
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    R_IDLE, R_SEND_REQ, R_WAIT_RESP, R_DONE, R_ERR
  } r_state_t;

  typedef enum logic [2:0] {
    P_IDLE, P_WAIT_REQ, P_SEND_RESP, P_DONE, P_ERR
  } p_state_t;

  typedef enum logic [1:0] {
    OWN_NONE, OWN_R, OWN_P
  } owner_t;

  r_state_t         r_r_state;
  p_state_t         r_p_state;
  owner_t           r_owner;
  logic             r_req_rcvd;
  logic             r_resp_rcvd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tx_valid;
  logic [MSG_W-1:0] r_tx_msg;
  logic             r_step_end;
  logic             r_timeout_err;

  logic w_clr;
  logic w_rx_req;
  logic w_rx_resp;
  logic w_both_done;
  logic w_cnt_run;
  logic w_to_hit;
  logic w_timeout;
  logic w_r_ack;
  logic w_p_ack;
  logic w_r_pend;
  logic w_p_pend;

  // Abort and loss of enable both return everything to idle
  assign w_clr       = i_train_error_req | ~i_step_en;
  assign w_rx_req    = i_msg_valid && (i_RX_SbMessage == REQ_CODE);
  assign w_rx_resp   = i_msg_valid && (i_RX_SbMessage == RESP_CODE) &&
                       ((r_r_state == R_SEND_REQ) || (r_r_state == R_WAIT_RESP));
  assign w_both_done = (r_r_state == R_DONE) && (r_p_state == P_DONE);
  // The step is timed from the edge that moves the FSMs out of IDLE
  assign w_cnt_run   = (r_r_state != R_IDLE) && !r_step_end && !r_timeout_err;
  assign w_to_hit    = w_cnt_run && (r_cnt == LP_CNT_LAST);
  // Completion landing on the timeout edge takes precedence
  assign w_timeout   = w_to_hit && !w_both_done;
  assign w_r_ack     = (r_owner == OWN_R) && i_falling_edge_busy;
  assign w_p_ack     = (r_owner == OWN_P) && i_falling_edge_busy;
  assign w_r_pend    = (r_r_state == R_SEND_REQ);
  // A captured partner REQ makes the responder pending at once so that it
  // wins a collision with the local REQ on the very first grant
  assign w_p_pend    = (r_p_state == P_SEND_RESP) ||
                       ((r_p_state == P_WAIT_REQ) && r_req_rcvd);

  // Requester FSM: send REQ, then wait for the partner RESP
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_r_state <= R_IDLE;
    end else if (w_clr) begin
      r_r_state <= R_IDLE;
    end else if (w_timeout) begin
      r_r_state <= R_ERR;
    end else begin
      case (r_r_state)
        R_IDLE:      if (i_step_en)   r_r_state <= R_SEND_REQ;
        R_SEND_REQ:  if (w_r_ack)     r_r_state <= R_WAIT_RESP;
        R_WAIT_RESP: if (r_resp_rcvd) r_r_state <= R_DONE;
        default:                      r_r_state <= r_r_state;
      endcase
    end
  end

  // Responder FSM: wait for the partner REQ, then send RESP
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_p_state <= P_IDLE;
    end else if (w_clr) begin
      r_p_state <= P_IDLE;
    end else if (w_timeout) begin
      r_p_state <= P_ERR;
    end else begin
      case (r_p_state)
        P_IDLE:      if (i_step_en)  r_p_state <= P_WAIT_REQ;
        P_WAIT_REQ:  if (r_req_rcvd) r_p_state <= P_SEND_RESP;
        P_SEND_RESP: if (w_p_ack)    r_p_state <= P_DONE;
        default:                     r_p_state <= r_p_state;
      endcase
    end
  end

  // Sticky capture of partner REQ / RESP while the step is enabled
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_req_rcvd  <= 1'b0;
      r_resp_rcvd <= 1'b0;
    end else if (w_clr) begin
      r_req_rcvd  <= 1'b0;
      r_resp_rcvd <= 1'b0;
    end else begin
      if (w_rx_req)  r_req_rcvd  <= 1'b1;
      if (w_rx_resp) r_resp_rcvd <= 1'b1;
    end
  end

  // TX arbiter: responder first; message held until the sideband accepts it
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= OWN_NONE;
      r_tx_valid <= 1'b0;
      r_tx_msg   <= '0;
    end else if (w_clr || w_timeout) begin
      r_owner    <= OWN_NONE;
      r_tx_valid <= 1'b0;
      r_tx_msg   <= '0;
    end else begin
      case (r_owner)
        OWN_NONE: begin
          if (w_p_pend) begin
            r_owner    <= OWN_P;
            r_tx_valid <= 1'b1;
            r_tx_msg   <= RESP_CODE;
          end else if (w_r_pend) begin
            r_owner    <= OWN_R;
            r_tx_valid <= 1'b1;
            r_tx_msg   <= REQ_CODE;
          end
        end
        default: begin
          if (i_falling_edge_busy) begin
            r_owner    <= OWN_NONE;
            r_tx_valid <= 1'b0;
            r_tx_msg   <= '0;
          end
        end
      endcase
    end
  end

  // Step timer: runs while the step is active and unresolved
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_run && !w_to_hit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Step status flags, held until the step is dropped or aborted
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_step_end    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (w_clr) begin
      r_step_end    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (w_both_done) begin
      r_step_end    <= 1'b1;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign o_TX_SbMessage = r_tx_msg;
  assign o_tx_valid     = r_tx_valid;
  assign o_step_end     = r_step_end;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_mbinit_step_handshake.sv
// Directed bench for mbinit_step_handshake with a queue of expected TX codes.
module tb_mbinit_step_handshake;

  localparam logic [3:0] REQ   = 4'd1;
  localparam logic [3:0] RESP  = 4'd2;
  localparam logic [3:0] NOISE = 4'd7;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       i_step_en;
  logic       i_train_error_req;
  logic [3:0] i_RX_SbMessage;
  logic       i_msg_valid;
  logic       i_falling_edge_busy;
  logic [3:0] o_TX_SbMessage;
  logic       o_tx_valid;
  logic       o_step_end;
  logic       o_timeout_err;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [3:0] prev_msg   = 4'd0;
  logic [3:0] mon_exp;

  mbinit_step_handshake #(
    .MSG_W(4), .REQ_CODE(REQ), .RESP_CODE(RESP), .TIMEOUT_CYC(20)
  ) dut (
    .CLK                 (CLK),
    .rst_n               (rst_n),
    .i_step_en           (i_step_en),
    .i_train_error_req   (i_train_error_req),
    .i_RX_SbMessage      (i_RX_SbMessage),
    .i_msg_valid         (i_msg_valid),
    .i_falling_edge_busy (i_falling_edge_busy),
    .o_TX_SbMessage      (o_TX_SbMessage),
    .o_tx_valid          (o_tx_valid),
    .o_step_end          (o_step_end),
    .o_timeout_err       (o_timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_step_end(input int max_cyc, input string tag);
    int n = 0;
    while (o_step_end !== 1'b1 && n < max_cyc) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(o_step_end), 32'd1);
  endtask

  // Scoreboard: each new TX message must match the next queued code and
  // stay unchanged for as long as it is valid
  always @(negedge CLK) begin
    if (o_tx_valid === 1'b1 && prev_valid !== 1'b1) begin
      chk("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        chk("tx_order", 32'(o_TX_SbMessage), 32'(mon_exp));
      end
    end else if (o_tx_valid === 1'b1 && prev_valid === 1'b1) begin
      chk("tx_stable", 32'(o_TX_SbMessage), 32'(prev_msg));
    end
    prev_valid = o_tx_valid;
    prev_msg   = o_TX_SbMessage;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_step_en = 1'b0; i_train_error_req = 1'b0;
    i_RX_SbMessage = 4'd0; i_msg_valid = 1'b0; i_falling_edge_busy = 1'b0;
    cyc(2);
    chk("rst_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_msg",   32'(o_TX_SbMessage), 32'd0);
    chk("rst_end",   32'(o_step_end), 32'd0);
    chk("rst_err",   32'(o_timeout_err), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Normal order: local REQ acked, partner REQ, partner RESP, RESP acked
    i_step_en = 1'b1; exp_q.push_back(REQ);
    cyc(2);
    chk("norm_lat_valid", 32'(o_tx_valid), 32'd1);
    chk("norm_req_code", 32'(o_TX_SbMessage), 32'(REQ));
    cyc(2);
    i_falling_edge_busy = 1'b1;
    cyc(1);
    i_falling_edge_busy = 1'b0;
    chk("norm_req_ack", 32'(o_tx_valid), 32'd0);
    i_msg_valid = 1'b1; i_RX_SbMessage = REQ; exp_q.push_back(RESP);
    cyc(1);
    i_msg_valid = 1'b0;
    cyc(1);
    chk("norm_resp_valid", 32'(o_tx_valid), 32'd1);
    chk("norm_resp_code", 32'(o_TX_SbMessage), 32'(RESP));
    cyc(3);
    i_msg_valid = 1'b1; i_RX_SbMessage = RESP;
    cyc(1);
    i_msg_valid = 1'b0;
    cyc(1);
    i_falling_edge_busy = 1'b1;
    cyc(1);
    i_falling_edge_busy = 1'b0;
    chk("norm_end_early", 32'(o_step_end), 32'd0);
    cyc(1);
    chk("norm_end", 32'(o_step_end), 32'd1);
    chk("norm_err", 32'(o_timeout_err), 32'd0);
    cyc(10);
    chk("norm_end_hold", 32'(o_step_end), 32'd1);
    chk("norm_err_hold", 32'(o_timeout_err), 32'd0);
    i_step_en = 1'b0;
    cyc(1);
    chk("norm_end_clr", 32'(o_step_end), 32'd0);

    // Collision: partner REQ on the enable cycle, RESP goes out first
    i_step_en = 1'b1; i_msg_valid = 1'b1; i_RX_SbMessage = REQ;
    exp_q.push_back(RESP); exp_q.push_back(REQ);
    cyc(1);
    i_msg_valid = 1'b0;
    cyc(1);
    chk("coll_first", 32'(o_TX_SbMessage), 32'(RESP));
    i_falling_edge_busy = 1'b1;
    cyc(1);
    i_falling_edge_busy = 1'b0;
    chk("coll_gap", 32'(o_tx_valid), 32'd0);
    cyc(1);
    chk("coll_second", 32'(o_TX_SbMessage), 32'(REQ));
    i_falling_edge_busy = 1'b1;
    cyc(1);
    i_falling_edge_busy = 1'b0;
    i_msg_valid = 1'b1; i_RX_SbMessage = RESP;
    cyc(1);
    i_msg_valid = 1'b0;
    wait_step_end(10, "coll_end");
    i_step_en = 1'b0;
    cyc(1);

    // Timeout with no partner traffic
    i_step_en = 1'b1; exp_q.push_back(REQ);
    cyc(2);
    chk("to_req_valid", 32'(o_tx_valid), 32'd1);
    cyc(18);
    chk("to_err_edge20", 32'(o_timeout_err), 32'd0);
    chk("to_valid_edge20", 32'(o_tx_valid), 32'd1);
    cyc(1);
    chk("to_err_edge21", 32'(o_timeout_err), 32'd1);
    chk("to_valid_drop", 32'(o_tx_valid), 32'd0);
    chk("to_msg_drop", 32'(o_TX_SbMessage), 32'd0);
    chk("to_no_end", 32'(o_step_end), 32'd0);
    cyc(5);
    chk("to_err_sticky", 32'(o_timeout_err), 32'd1);
    chk("to_valid_idle", 32'(o_tx_valid), 32'd0);
    i_step_en = 1'b0;
    cyc(1);
    chk("to_err_clr", 32'(o_timeout_err), 32'd0);

    // Abort while REQ is on the wire, then re-enable
    i_step_en = 1'b1; exp_q.push_back(REQ);
    cyc(2);
    chk("ab_valid", 32'(o_tx_valid), 32'd1);
    i_train_error_req = 1'b1;
    cyc(1);
    chk("ab_valid_clr", 32'(o_tx_valid), 32'd0);
    chk("ab_msg_clr", 32'(o_TX_SbMessage), 32'd0);
    chk("ab_end_clr", 32'(o_step_end), 32'd0);
    chk("ab_err_clr", 32'(o_timeout_err), 32'd0);
    cyc(2);
    chk("ab_held_idle", 32'(o_tx_valid), 32'd0);
    i_train_error_req = 1'b0; i_step_en = 1'b0;
    cyc(1);
    i_step_en = 1'b1; exp_q.push_back(REQ);
    cyc(1);
    chk("ab_re_lat1", 32'(o_tx_valid), 32'd0);
    cyc(1);
    chk("ab_re_valid", 32'(o_tx_valid), 32'd1);
    chk("ab_re_code", 32'(o_TX_SbMessage), 32'(REQ));
    i_step_en = 1'b0;
    cyc(1);
    chk("ab_en_drop", 32'(o_tx_valid), 32'd0);

    // Noise: RESP while requester IDLE and an unknown code are ignored
    i_step_en = 1'b1; i_msg_valid = 1'b1; i_RX_SbMessage = RESP;
    exp_q.push_back(REQ);
    cyc(1);
    i_RX_SbMessage = NOISE;
    cyc(1);
    i_msg_valid = 1'b0;
    chk("nz_req_code", 32'(o_TX_SbMessage), 32'(REQ));
    cyc(1);
    i_falling_edge_busy = 1'b1;
    cyc(1);
    i_falling_edge_busy = 1'b0;
    cyc(1);
    i_msg_valid = 1'b1; i_RX_SbMessage = REQ; exp_q.push_back(RESP);
    cyc(1);
    i_msg_valid = 1'b0;
    cyc(1);
    chk("nz_resp_code", 32'(o_TX_SbMessage), 32'(RESP));
    cyc(1);
    i_falling_edge_busy = 1'b1;
    cyc(1);
    i_falling_edge_busy = 1'b0;
    cyc(3);
    chk("nz_no_end", 32'(o_step_end), 32'd0);
    i_msg_valid = 1'b1; i_RX_SbMessage = RESP;
    cyc(1);
    i_msg_valid = 1'b0;
    cyc(1);
    chk("nz_end_early", 32'(o_step_end), 32'd0);
    cyc(1);
    chk("nz_end", 32'(o_step_end), 32'd1);
    i_step_en = 1'b0;
    cyc(1);

    // Asynchronous reset while the requester waits for RESP
    i_step_en = 1'b1; exp_q.push_back(REQ);
    cyc(2);
    i_falling_edge_busy = 1'b1;
    cyc(1);
    i_falling_edge_busy = 1'b0;
    i_msg_valid = 1'b1; i_RX_SbMessage = REQ; exp_q.push_back(RESP);
    cyc(1);
    i_msg_valid = 1'b0;
    cyc(1);
    chk("ar_pre_valid", 32'(o_tx_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(o_tx_valid), 32'd0);
    chk("ar_msg", 32'(o_TX_SbMessage), 32'd0);
    chk("ar_end", 32'(o_step_end), 32'd0);
    chk("ar_err", 32'(o_timeout_err), 32'd0);
    cyc(1);
    i_step_en = 1'b0; rst_n = 1'b1;
    cyc(2);
    chk("ar_post_valid", 32'(o_tx_valid), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mbinit_step_handshake.md
Name: mbinit_step_handshake

Overview:
- Parametrised MBINIT sideband handshake engine for one training step, e.g. CAL or REPAIRCLK.
- Runs a local requester (send REQ, await RESP) and a local responder (await partner REQ, send RESP) concurrently.
- Arbitrates both onto a single sideband TX port, so a per-step wrapper no longer needs two sub-modules plus glue.
- Adds configurable message codes and width, a step timeout with error flag, and synchronous abort.

Parameters:
- MSG_W, 4, width of sideband message code.
- REQ_CODE, 4'd1, code sent and recognised as the step request.
- RESP_CODE, 4'd2, code sent and recognised as the step response.
- TIMEOUT_CYC, 1000, cycles from step start to timeout error (≥2).
- CNT_W, $clog2(TIMEOUT_CYC), timeout counter width.

Ports:
- CLK  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_step_en  in  1  step enable, level; held high for the duration of the step
- i_train_error_req  in  1  abort request, level
- i_RX_SbMessage  in  MSG_W  decoded received sideband code
- i_msg_valid  in  1  i_RX_SbMessage valid this cycle
- i_falling_edge_busy  in  1  sideband accepted the current TX message
- o_TX_SbMessage  out  MSG_W  message to transmit
- o_tx_valid  out  1  o_TX_SbMessage valid
- o_step_end  out  1  both handshakes complete
- o_timeout_err  out  1  step timed out

Behaviour:
- Reset: all outputs 0, both FSMs IDLE, flags and counter cleared. All outputs are registered.
- Requester FSM (R): IDLE → SEND_REQ → WAIT_RESP → DONE.
  - IDLE→SEND_REQ when i_step_en=1.
  - SEND_REQ→WAIT_RESP on the edge where R owns TX and i_falling_edge_busy=1.
  - WAIT_RESP→DONE when resp_rcvd=1.
- Responder FSM (P): IDLE → WAIT_REQ → SEND_RESP → DONE.
  - IDLE→WAIT_REQ when i_step_en=1.
  - WAIT_REQ→SEND_RESP when req_rcvd=1.
  - SEND_RESP→DONE on i_falling_edge_busy while P owns TX.
- RX capture, only while i_step_en=1:
  - i_msg_valid && code==REQ_CODE sets sticky req_rcvd.
  - i_msg_valid && code==RESP_CODE sets sticky resp_rcvd; accepted in SEND_REQ or WAIT_RESP.
  - Other codes ignored.
  - A flag set in the same cycle as the state check is consumed on the following edge.
- TX arbitration:
  - Owner register {NONE, R, P}.
  - When owner=NONE and a requester is pending, the owner is granted on the next edge. P has priority when both are pending.
  - On grant: o_tx_valid=1 and o_TX_SbMessage=REQ_CODE (R) or RESP_CODE (P). Both are held stable until i_falling_edge_busy=1.
  - On the edge after i_falling_edge_busy: o_tx_valid=0, message=0, owner=NONE. Earliest re-grant is the following edge, giving at least one idle cycle between messages.
  - i_falling_edge_busy while owner=NONE is ignored.
- Latency: with the sideband idle, o_tx_valid rises one edge after SEND_REQ is entered. From i_step_en rising that is 2 edges to o_tx_valid.
- o_step_end: set on the edge after both FSMs are in DONE. Held while i_step_en=1.
- Timeout:
  - Counter clears while i_step_en=0. It increments each cycle while i_step_en=1 and neither o_step_end nor o_timeout_err is set.
  - When count==TIMEOUT_CYC-1, o_timeout_err is set on the next edge.
  - At that edge: both FSMs go to ERR, o_tx_valid=0, owner=NONE.
  - o_timeout_err is sticky until i_step_en=0.
  - If step completion and timeout land on the same edge, completion wins: o_step_end=1, o_timeout_err=0.
- Abort: i_train_error_req=1 has the highest priority. On the next edge both FSMs go to IDLE and all flags, counter and outputs clear. The block stays idle while i_train_error_req=1.
- Mid-step i_step_en fall has the same effect as abort. A new rising edge of i_step_en restarts the step from scratch.

Test Plan:
- Normal order: en=1; partner REQ at cycle 5; ack local REQ at cycle 4; partner RESP at cycle 10; ack RESP → o_tx_valid seen with REQ_CODE then RESP_CODE, o_step_end=1 at ack+2, o_timeout_err=0.
- Collision: partner REQ on the same cycle as en rises → RESP_CODE granted first; REQ_CODE follows after ≥1 idle cycle; o_TX_SbMessage is never changed while o_tx_valid=1 without an ack.
- Timeout: TIMEOUT_CYC=20, no partner traffic → o_timeout_err=1 exactly 21 edges after en rise, o_tx_valid=0 thereafter; en=0 clears it.
- Abort: i_train_error_req pulse while o_tx_valid=1 → next edge all outputs 0; re-enable produces a fresh REQ.
- Noise: unexpected code 4'd7 and RESP_CODE while requester IDLE → ignored, no state change.
- Async reset asserted mid-WAIT_RESP → all outputs 0 immediately, without a clock edge.
